// File: rtl/drive_pkg.sv
// Shared definitions for the drive instruction sequencer and its assembler model:
// opcodes, sequencer state encoding and instruction field helpers.
package drive_pkg;

    localparam int DEF_PC_WIDTH   = 11;
    localparam int DEF_INST_WIDTH = 32;
    localparam int DEF_DUR_WIDTH  = 16;
    localparam int DEF_IDX_WIDTH  = 8;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PLAY = 2'b01;
    localparam logic [1:0] OP_JUMP = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Extracts a width-bit field starting at lsb from an instruction zero-extended to 64 bits.
    function automatic logic [63:0] inst_field(input logic [63:0] inst, input int lsb, input int width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (inst >> lsb) & mask;
    endfunction

    function automatic logic [DEF_INST_WIDTH-1:0] make_inst(input logic [1:0] op,
                                                            input logic [DEF_DUR_WIDTH-1:0] dur,
                                                            input logic [DEF_PC_WIDTH-1:0] payload);
        logic [DEF_INST_WIDTH-1:0] inst;
        inst = '0;
        inst[DEF_INST_WIDTH-1 -: 2] = op;
        inst[DEF_INST_WIDTH-3 -: DEF_DUR_WIDTH] = dur;
        inst[DEF_PC_WIDTH-1:0] = payload;
        return inst;
    endfunction

endpackage

// File: rtl/drive_dur_cnt.sv
// Loadable down-counter tracking the remaining EXEC cycles of the current instruction.
// The loaded value counts the current cycle, so last is combinational on the load cycle too.
module drive_dur_cnt #(
    parameter int DUR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DUR_WIDTH-1:0] load_val,
    input  logic                 en,
    output logic                 last
);

    logic [DUR_WIDTH-1:0] cnt_q;
    logic [DUR_WIDTH-1:0] cur;

    assign cur  = load ? load_val : cnt_q;
    assign last = (cur == DUR_WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cur - DUR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/drive_seq.sv
// Drive instruction sequencer: fetches instructions at PC, holds each for its duration,
// drives the waveform generator and hands the next PC back to drive_pc.
module drive_seq
    import drive_pkg::*;
#(
    parameter int PC_WIDTH   = 11,
    parameter int INST_WIDTH = 32,
    parameter int DUR_WIDTH  = 16,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PC_WIDTH-1:0]   start_pc,
    input  logic                  abort,
    input  logic [PC_WIDTH-1:0]   PC,
    output logic                  update_pc,
    output logic [PC_WIDTH-1:0]   next_PC,
    output logic                  imem_ren,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  pulse_valid,
    output logic [IDX_WIDTH-1:0]  pulse_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int FIELD_MAX = (PC_WIDTH > IDX_WIDTH) ? PC_WIDTH : IDX_WIDTH;

    generate
        if ((INST_WIDTH < 2 + DUR_WIDTH + FIELD_MAX) || (INST_WIDTH > 64)) begin : g_bad_widths
            $error("drive_seq: INST_WIDTH cannot hold opcode, duration and payload fields");
        end
    endgenerate

    seq_state_t state_q, state_d;
    logic                  first_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic                  done_q;

    logic [INST_WIDTH-1:0] cur_inst;
    logic [1:0]            opcode;
    logic [DUR_WIDTH-1:0]  dur_raw;
    logic [DUR_WIDTH-1:0]  dur_eff;
    logic [PC_WIDTH-1:0]   target;
    logic [IDX_WIDTH-1:0]  idx;
    logic                  cnt_last;
    logic                  exec_last;
    logic                  in_exec;
    logic                  halt_now;

    // The ROM word is only valid in the first EXEC cycle; later cycles use the captured copy.
    assign cur_inst = first_q ? imem_rdata : inst_q;
    assign opcode   = 2'(inst_field(64'(cur_inst), INST_WIDTH - 2, 2));
    assign dur_raw  = DUR_WIDTH'(inst_field(64'(cur_inst), INST_WIDTH - 2 - DUR_WIDTH, DUR_WIDTH));
    assign target   = PC_WIDTH'(inst_field(64'(cur_inst), 0, PC_WIDTH));
    assign idx      = IDX_WIDTH'(inst_field(64'(cur_inst), 0, IDX_WIDTH));
    assign dur_eff  = (dur_raw == '0) ? DUR_WIDTH'(1) : dur_raw;

    assign in_exec   = (state_q == ST_EXEC);
    assign exec_last = (opcode == OP_JUMP) || cnt_last;
    assign halt_now  = in_exec && !abort && (opcode == OP_HALT);

    drive_dur_cnt #(
        .DUR_WIDTH(DUR_WIDTH)
    ) u_dur_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (first_q),
        .load_val (dur_eff),
        .en       (in_exec),
        .last     (cnt_last)
    );

    assign imem_addr = PC;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign done      = done_q || halt_now;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
            inst_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_q == ST_FETCH) && !abort;
            if (in_exec && first_q) begin
                inst_q <= imem_rdata;
            end
            if (!abort && start && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
                done_q <= 1'b0;
            end else if (halt_now) begin
                done_q <= 1'b1;
            end
        end
    end

    // Abort overrides every state and suppresses all strobes in the cycle it is seen.
    always_comb begin
        state_d     = state_q;
        update_pc   = 1'b0;
        next_PC     = '0;
        imem_ren    = 1'b0;
        pulse_valid = 1'b0;
        pulse_idx   = '0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        update_pc = 1'b1;
                        next_PC   = start_pc;
                        state_d   = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    imem_ren = 1'b1;
                    state_d  = ST_EXEC;
                end
                ST_EXEC: begin
                    if (opcode == OP_HALT) begin
                        state_d = ST_DONE;
                    end else begin
                        if (opcode == OP_PLAY) begin
                            pulse_valid = 1'b1;
                            pulse_idx   = idx;
                        end
                        if (exec_last) begin
                            update_pc = 1'b1;
                            next_PC   = (opcode == OP_JUMP) ? target : PC + PC_WIDTH'(1);
                            state_d   = ST_FETCH;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drive_seq.sv
// Directed bench for drive_seq with a behavioural drive_pc register and a 1-cycle ROM.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_drive_seq;
    import drive_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] start_pc;
    logic        abort;
    logic [10:0] pc;
    logic        update_pc;
    logic [10:0] next_PC;
    logic        imem_ren;
    logic [10:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        pulse_valid;
    logic [7:0]  pulse_idx;
    logic        busy;
    logic        done;

    logic [31:0] rom [0:2047];

    int vectors;
    int miscompares;

    drive_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_pc    (start_pc),
        .abort       (abort),
        .PC          (pc),
        .update_pc   (update_pc),
        .next_PC     (next_PC),
        .imem_ren    (imem_ren),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .pulse_valid (pulse_valid),
        .pulse_idx   (pulse_idx),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else if (update_pc) begin
            pc <= next_PC;
        end
    end

    always @(posedge clk) begin
        if (imem_ren) begin
            imem_rdata <= rom[imem_addr];
        end
    end

    task automatic apply_stimulus(input logic s, input logic [10:0] sp, input logic a);
        @(negedge clk);
        start    = s;
        start_pc = sp;
        abort    = a;
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({update_pc, next_PC, imem_ren, pulse_valid, pulse_idx, busy, done} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got upd=%b npc=%0d ren=%b pv=%b idx=%0d busy=%b done=%b, expected all 0",
                     update_pc, next_PC, imem_ren, pulse_valid, pulse_idx, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(1'b0, 11'd0, 1'b0);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || update_pc !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: got busy=%b done=%b upd=%b, expected 0 0 0", busy, done, update_pc);
        end
    endtask

    // NOP d=3 at 0, HALT at 1: update_pc in cycles 0 and 4, done from cycle 6.
    task automatic test_nop_halt();
        apply_stimulus(1'b1, 11'd0, 1'b0);
        vectors++;
        if (update_pc !== 1'b1 || next_PC !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL nop_start: got upd=%b npc=%0d, expected 1 0", update_pc, next_PC);
        end
        for (int c = 1; c <= 8; c++) begin
            apply_stimulus(1'b0, 11'd0, 1'b0);
            vectors++;
            if (update_pc !== 1'(c == 4) || imem_ren !== 1'(c == 1 || c == 5) ||
                busy !== 1'(c <= 6) || done !== 1'(c >= 6)) begin
                miscompares++;
                $display("[TB] FAIL nop_cycle%0d: got upd=%b ren=%b busy=%b done=%b, expected %b %b %b %b",
                         c, update_pc, imem_ren, busy, done, 1'(c == 4), 1'(c == 1 || c == 5),
                         1'(c <= 6), 1'(c >= 6));
            end
            if (c == 4) begin
                vectors++;
                if (next_PC !== 11'd1) begin
                    miscompares++;
                    $display("[TB] FAIL nop_next_pc: got %0d, expected 1", next_PC);
                end
            end
        end
        vectors++;
        if (pc !== 11'd1) begin
            miscompares++;
            $display("[TB] FAIL nop_final_pc: got %0d, expected 1", pc);
        end
    endtask

    // PLAY idx=5 d=4 at 10: pulses in cycles 2..5, update_pc with 11 in cycle 5.
    task automatic test_play();
        int pulses;
        pulses = 0;
        apply_stimulus(1'b1, 11'd10, 1'b0);
        vectors++;
        if (update_pc !== 1'b1 || next_PC !== 11'd10 || done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL play_start: got upd=%b npc=%0d done=%b, expected 1 10 1", update_pc, next_PC, done);
        end
        for (int c = 1; c <= 7; c++) begin
            apply_stimulus(1'b0, 11'd0, 1'b0);
            if (pulse_valid === 1'b1) pulses++;
            vectors++;
            if (pulse_valid !== 1'(c >= 2 && c <= 5) || update_pc !== 1'(c == 5)) begin
                miscompares++;
                $display("[TB] FAIL play_cycle%0d: got pv=%b upd=%b, expected %b %b",
                         c, pulse_valid, update_pc, 1'(c >= 2 && c <= 5), 1'(c == 5));
            end
            if (c >= 2 && c <= 5) begin
                vectors++;
                if (pulse_idx !== 8'd5) begin
                    miscompares++;
                    $display("[TB] FAIL play_idx%0d: got %0d, expected 5", c, pulse_idx);
                end
            end
            if (c == 5) begin
                vectors++;
                if (next_PC !== 11'd11) begin
                    miscompares++;
                    $display("[TB] FAIL play_next_pc: got %0d, expected 11", next_PC);
                end
            end
        end
        vectors++;
        if (pulses != 4 || done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL play_count: got pulses=%0d done=%b, expected 4 1", pulses, done);
        end
    endtask

    // JUMP target=7 d=9 at 2: dur ignored, redirect in cycle 2, fetch from 7 in cycle 3.
    task automatic test_jump();
        apply_stimulus(1'b1, 11'd2, 1'b0);
        apply_stimulus(1'b0, 11'd0, 1'b0);
        vectors++;
        if (imem_ren !== 1'b1 || imem_addr !== 11'd2) begin
            miscompares++;
            $display("[TB] FAIL jump_fetch: got ren=%b addr=%0d, expected 1 2", imem_ren, imem_addr);
        end
        apply_stimulus(1'b0, 11'd0, 1'b0);
        vectors++;
        if (update_pc !== 1'b1 || next_PC !== 11'd7) begin
            miscompares++;
            $display("[TB] FAIL jump_target: got upd=%b npc=%0d, expected 1 7", update_pc, next_PC);
        end
        apply_stimulus(1'b0, 11'd0, 1'b0);
        vectors++;
        if (imem_ren !== 1'b1 || imem_addr !== 11'd7) begin
            miscompares++;
            $display("[TB] FAIL jump_refetch: got ren=%b addr=%0d, expected 1 7", imem_ren, imem_addr);
        end
        apply_stimulus(1'b0, 11'd0, 1'b0);
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL jump_halt: got done=%b, expected 1", done);
        end
    endtask

    // NOP d=0 at 2047: single EXEC cycle, PC wraps to 0, then program at 0 runs to HALT.
    task automatic test_wrap();
        bit seen_done;
        seen_done = 1'b0;
        apply_stimulus(1'b1, 11'd2047, 1'b0);
        apply_stimulus(1'b0, 11'd0, 1'b0);
        apply_stimulus(1'b0, 11'd0, 1'b0);
        vectors++;
        if (update_pc !== 1'b1 || next_PC !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL wrap_next_pc: got upd=%b npc=%0d, expected 1 0", update_pc, next_PC);
        end
        apply_stimulus(1'b0, 11'd0, 1'b0);
        vectors++;
        if (imem_ren !== 1'b1 || imem_addr !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL wrap_fetch: got ren=%b addr=%0d, expected 1 0", imem_ren, imem_addr);
        end
        for (int c = 0; c < 20 && !seen_done; c++) begin
            apply_stimulus(1'b0, 11'd0, 1'b0);
            if (done === 1'b1) seen_done = 1'b1;
        end
        vectors++;
        if (!seen_done) begin
            miscompares++;
            $display("[TB] FAIL wrap_done_timeout: got done=%b, expected 1 within 20 cycles", done);
        end
    endtask

    // PLAY idx=9 d=6 at 20: start while busy ignored, abort kills pulse and update.
    task automatic test_abort();
        apply_stimulus(1'b1, 11'd20, 1'b0);
        apply_stimulus(1'b0, 11'd0, 1'b0);
        apply_stimulus(1'b1, 11'd30, 1'b0);
        vectors++;
        if (update_pc !== 1'b0 || pulse_valid !== 1'b1 || pulse_idx !== 8'd9) begin
            miscompares++;
            $display("[TB] FAIL busy_start: got upd=%b pv=%b idx=%0d, expected 0 1 9", update_pc, pulse_valid, pulse_idx);
        end
        apply_stimulus(1'b0, 11'd0, 1'b1);
        vectors++;
        if (update_pc !== 1'b0 || pulse_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_cycle: got upd=%b pv=%b, expected 0 0", update_pc, pulse_valid);
        end
        apply_stimulus(1'b0, 11'd0, 1'b0);
        vectors++;
        if (busy !== 1'b0 || pulse_valid !== 1'b0 || update_pc !== 1'b0 || pc !== 11'd20) begin
            miscompares++;
            $display("[TB] FAIL abort_after: got busy=%b pv=%b upd=%b pc=%0d, expected 0 0 0 20",
                     busy, pulse_valid, update_pc, pc);
        end
        apply_stimulus(1'b1, 11'd30, 1'b1);
        vectors++;
        if (update_pc !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL start_with_abort: got upd=%b, expected 0", update_pc);
        end
        apply_stimulus(1'b0, 11'd0, 1'b0);
        vectors++;
        if (busy !== 1'b0 || pc !== 11'd20) begin
            miscompares++;
            $display("[TB] FAIL start_with_abort_after: got busy=%b pc=%0d, expected 0 20", busy, pc);
        end
    endtask

    // PLAY idx=3 d=8 at 40 interrupted by reset, then a clean restart at 3 (HALT).
    task automatic test_async_reset();
        apply_stimulus(1'b1, 11'd40, 1'b0);
        apply_stimulus(1'b0, 11'd0, 1'b0);
        apply_stimulus(1'b0, 11'd0, 1'b0);
        apply_stimulus(1'b0, 11'd0, 1'b0);
        vectors++;
        if (pulse_valid !== 1'b1 || pulse_idx !== 8'd3) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_play: got pv=%b idx=%0d, expected 1 3", pulse_valid, pulse_idx);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({update_pc, next_PC, imem_ren, imem_addr, pulse_valid, pulse_idx, busy, done} !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got upd=%b npc=%0d ren=%b addr=%0d pv=%b idx=%0d busy=%b done=%b, expected all 0",
                     update_pc, next_PC, imem_ren, imem_addr, pulse_valid, pulse_idx, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(1'b1, 11'd3, 1'b0);
        vectors++;
        if (update_pc !== 1'b1 || next_PC !== 11'd3) begin
            miscompares++;
            $display("[TB] FAIL restart_start: got upd=%b npc=%0d, expected 1 3", update_pc, next_PC);
        end
        apply_stimulus(1'b0, 11'd0, 1'b0);
        vectors++;
        if (imem_ren !== 1'b1 || imem_addr !== 11'd3) begin
            miscompares++;
            $display("[TB] FAIL restart_fetch: got ren=%b addr=%0d, expected 1 3", imem_ren, imem_addr);
        end
        apply_stimulus(1'b0, 11'd0, 1'b0);
        vectors++;
        if (done !== 1'b1 || pulse_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL restart_halt: got done=%b pv=%b, expected 1 0", done, pulse_valid);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at 200000 ns, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        start       = 1'b0;
        start_pc    = '0;
        abort       = 1'b0;
        for (int a = 0; a < 2048; a++) rom[a] = make_inst(OP_HALT, 16'd0, 11'd0);
        rom[0]    = make_inst(OP_NOP,  16'd3, 11'd0);
        rom[1]    = make_inst(OP_HALT, 16'd0, 11'd0);
        rom[2]    = make_inst(OP_JUMP, 16'd9, 11'd7);
        rom[7]    = make_inst(OP_HALT, 16'd0, 11'd0);
        rom[10]   = make_inst(OP_PLAY, 16'd4, 11'd5);
        rom[11]   = make_inst(OP_HALT, 16'd0, 11'd0);
        rom[20]   = make_inst(OP_PLAY, 16'd6, 11'd9);
        rom[40]   = make_inst(OP_PLAY, 16'd8, 11'd3);
        rom[2047] = make_inst(OP_NOP,  16'd0, 11'd0);

        test_reset();
        test_nop_halt();
        test_play();
        test_jump();
        test_wrap();
        test_abort();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
